// File: rtl/wieg_strategie.sv
// wieg_strategie: turns the stress evaluator's per-tick verdicts into rocking
// setpoints (amplitude, frequency) for the motor driver. Rising stress reverses
// the search direction, stagnant stress triggers a periodic exploratory step,
// falling stress holds the setting and eventually declares the baby calm.
module wieg_strategie #(
    parameter int unsigned AMP_INIT  = 2,
    parameter int unsigned FREQ_INIT = 2,
    parameter int unsigned STALE_MAX = 4,
    parameter int unsigned CALM_MAX  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk12,
    input  logic       aan,
    input  logic       gedaald,
    input  logic       gelijk,
    output logic [2:0] amplitude,
    output logic [2:0] frequentie,
    output logic       nieuw,
    output logic       klaar
);

    typedef enum logic {ZOEK = 1'b0, RUST = 1'b1} state_t;
    typedef enum logic {DIM_AMP = 1'b0, DIM_FREQ = 1'b1} dim_t;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    // Outcome of one STEP: new setpoints, possibly switched dimension and
    // direction, and whether any setpoint actually moved.
    typedef struct packed {
        dim_t       dim;
        dir_t       dir;
        logic [2:0] amp;
        logic [2:0] freq;
        logic       changed;
    } step_t;

    localparam logic [2:0] AMP_RST   = 3'(AMP_INIT);
    localparam logic [2:0] FREQ_RST  = 3'(FREQ_INIT);
    localparam logic [3:0] STALE_LIM = 4'(STALE_MAX);
    localparam logic [3:0] CALM_LIM  = 4'(CALM_MAX);

    state_t     state_q, state_d;
    dim_t       dim_q, dim_d;
    dir_t       dir_q, dir_d;
    logic [3:0] stale_q, stale_d;
    logic [3:0] calm_q, calm_d;
    logic [2:0] amp_d, freq_d;
    logic       nieuw_d, klaar_d;

    step_t      step_fwd;   // exploratory step in the current direction
    step_t      step_rev;   // step after reversing the direction
    step_t      sel;
    logic       take;

    function automatic dir_t flip(input dir_t d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

    function automatic logic [2:0] bump(input logic [2:0] v, input dir_t d);
        return (d == DIR_UP) ? v + 3'd1 : v - 3'd1;
    endfunction

    // Move the active dimension one unit towards d; at its bound hand over to
    // the other dimension; with both at the bound nothing moves and the
    // search direction turns around. Setpoints never wrap.
    function automatic step_t do_step(input dim_t d_dim, input dir_t d,
                                      input logic [2:0] amp,
                                      input logic [2:0] freq);
        step_t      r;
        logic [2:0] bnd;
        logic [2:0] act;
        logic [2:0] oth;
        bnd       = (d == DIR_UP) ? 3'd7 : 3'd0;
        act       = (d_dim == DIM_AMP) ? amp : freq;
        oth       = (d_dim == DIM_AMP) ? freq : amp;
        r.dim     = d_dim;
        r.dir     = d;
        r.amp     = amp;
        r.freq    = freq;
        r.changed = 1'b0;
        if (act != bnd) begin
            if (d_dim == DIM_AMP) r.amp  = bump(amp, d);
            else                  r.freq = bump(freq, d);
            r.changed = 1'b1;
        end else begin
            r.dim = (d_dim == DIM_AMP) ? DIM_FREQ : DIM_AMP;
            if (oth != bnd) begin
                if (d_dim == DIM_AMP) r.freq = bump(freq, d);
                else                  r.amp  = bump(amp, d);
                r.changed = 1'b1;
            end else begin
                r.dir = flip(d);
            end
        end
        return r;
    endfunction

    // Next-state and next-output decision for the current cycle.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        dim_d    = dim_q;
        dir_d    = dir_q;
        stale_d  = stale_q;
        calm_d   = calm_q;
        amp_d    = amplitude;
        freq_d   = frequentie;
        nieuw_d  = 1'b0;
        klaar_d  = klaar;
        take     = 1'b0;
        step_fwd = do_step(dim_q, dir_q, amplitude, frequentie);
        step_rev = do_step(dim_q, flip(dir_q), amplitude, frequentie);
        sel      = step_fwd;

        if (!aan) begin
            state_d = ZOEK;
            dim_d   = DIM_AMP;
            dir_d   = DIR_UP;
            stale_d = '0;
            calm_d  = '0;
            amp_d   = AMP_RST;
            freq_d  = FREQ_RST;
            klaar_d = 1'b0;
        end else if (clk12) begin
            case (state_q)
                ZOEK: begin
                    if (gedaald) begin
                        stale_d = '0;
                        if (calm_q + 4'd1 == CALM_LIM) begin
                            state_d = RUST;
                            klaar_d = 1'b1;
                            calm_d  = '0;
                        end else begin
                            calm_d = calm_q + 4'd1;
                        end
                    end else if (gelijk) begin
                        calm_d = '0;
                        if (stale_q + 4'd1 == STALE_LIM) begin
                            sel     = step_fwd;
                            take    = 1'b1;
                            stale_d = '0;
                        end else begin
                            stale_d = stale_q + 4'd1;
                        end
                    end else begin
                        calm_d  = '0;
                        stale_d = '0;
                        sel     = step_rev;
                        take    = 1'b1;
                    end
                end
                RUST: begin
                    stale_d = '0;
                    calm_d  = '0;
                    if (!gedaald && !gelijk) begin
                        state_d = ZOEK;
                        klaar_d = 1'b0;
                        sel     = step_rev;
                        take    = 1'b1;
                    end
                end
                default: state_d = ZOEK;
            endcase

            if (take) begin
                dim_d   = sel.dim;
                dir_d   = sel.dir;
                amp_d   = sel.amp;
                freq_d  = sel.freq;
                nieuw_d = sel.changed;
            end
        end
    end

    // State and registered outputs, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= ZOEK;
            dim_q      <= DIM_AMP;
            dir_q      <= DIR_UP;
            stale_q    <= '0;
            calm_q     <= '0;
            amplitude  <= AMP_RST;
            frequentie <= FREQ_RST;
            nieuw      <= 1'b0;
            klaar      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dim_q      <= dim_d;
            dir_q      <= dir_d;
            stale_q    <= stale_d;
            calm_q     <= calm_d;
            amplitude  <= amp_d;
            frequentie <= freq_d;
            nieuw      <= nieuw_d;
            klaar      <= klaar_d;
        end
    end

endmodule

// File: tb/tb_wieg_strategie.sv
// Scoreboard bench for wieg_strategie: the driver applies one input vector per
// cycle and queues the hand-computed outputs for the following cycle; the
// monitor pops and compares after every rising edge.
module tb_wieg_strategie;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk12 = 1'b0;
    logic       aan = 1'b0;
    logic       gedaald = 1'b0;
    logic       gelijk = 1'b0;
    logic [2:0] amplitude;
    logic [2:0] frequentie;
    logic       nieuw;
    logic       klaar;

    typedef struct packed {
        logic [2:0] amp;
        logic [2:0] freq;
        logic       n;
        logic       k;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    wieg_strategie dut (
        .clk        (clk),
        .reset      (reset),
        .clk12      (clk12),
        .aan        (aan),
        .gedaald    (gedaald),
        .gelijk     (gelijk),
        .amplitude  (amplitude),
        .frequentie (frequentie),
        .nieuw      (nieuw),
        .klaar      (klaar)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the outputs
    // expected after the next rising edge.
    task automatic cyc(input logic r, input logic a, input logic t,
                       input logic gd, input logic gl,
                       input int ea, input int ef, input logic en,
                       input logic ek, input string nm);
        exp_t e;
        @(negedge clk);
        reset   = r;
        aan     = a;
        clk12   = t;
        gedaald = gd;
        gelijk  = gl;
        e.amp   = 3'(ea);
        e.freq  = 3'(ef);
        e.n     = en;
        e.k     = ek;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic idle(input int ea, input int ef, input logic ek, input string nm);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ea, ef, 1'b0, ek, nm);
    endtask

    task automatic tick(input logic gd, input logic gl, input int ea, input int ef,
                        input logic en, input logic ek, input string nm);
        cyc(1'b0, 1'b1, 1'b1, gd, gl, ea, ef, en, ek, nm);
    endtask

    // Four SAME ticks: three hold the setpoints, the fourth applies a step.
    task automatic same4(input int a0, input int f0, input int a1, input int f1,
                         input logic en, input string nm);
        for (int j = 0; j < 3; j++) tick(1'b0, 1'b1, a0, f0, 1'b0, 1'b0, nm);
        tick(1'b0, 1'b1, a1, f1, en, 1'b0, nm);
    endtask

    // Monitor: after each rising edge compare the DUT outputs with the oldest
    // queued expectation.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if ({amplitude, frequentie, nieuw, klaar} !== {e.amp, e.freq, e.n, e.k}) begin
                    errors++;
                    $display("FAIL %s: got amp=%0d freq=%0d nieuw=%b klaar=%b, want amp=%0d freq=%0d nieuw=%b klaar=%b",
                             nm, amplitude, frequentie, nieuw, klaar, e.amp, e.freq, e.n, e.k);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, and reset winning over a RISE tick in the same cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, "reset");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, "reset_over_tick");
        idle(2, 2, 1'b0, "idle_after_reset");

        // 1: four SAME ticks step amplitude up, one-cycle nieuw.
        same4(2, 2, 3, 2, 1'b1, "same_step_amp_up");
        idle(3, 2, 1'b0, "nieuw_one_cycle");

        // 2: RISE reverses to DOWN, next RISE back to UP.
        tick(1'b0, 1'b0, 2, 2, 1'b1, 1'b0, "rise_down");
        idle(2, 2, 1'b0, "idle_after_rise");
        tick(1'b0, 1'b0, 3, 2, 1'b1, 1'b0, "rise_up");

        // 3: climb amplitude to 7, then hand over to frequency.
        for (int s = 1; s <= 4; s++) same4(2 + s, 2, 3 + s, 2, 1'b1, "climb_amp");
        same4(7, 2, 7, 3, 1'b1, "handover_to_freq");

        // 4: climb frequency to 7; both at bound turns dir to DOWN with no change.
        for (int s = 1; s <= 4; s++) same4(7, 2 + s, 7, 3 + s, 1'b1, "climb_freq");
        same4(7, 7, 7, 7, 1'b0, "both_at_bound");
        same4(7, 7, 6, 7, 1'b1, "step_after_turn");

        // 5: six DROP ticks reach RUST; DROP+gelijk and SAME stay; RISE leaves.
        for (int j = 0; j < 5; j++) tick(1'b1, 1'b0, 6, 7, 1'b0, 1'b0, "drop_count");
        tick(1'b1, 1'b0, 6, 7, 1'b0, 1'b1, "enter_rust");
        tick(1'b1, 1'b1, 6, 7, 1'b0, 1'b1, "rust_drop_gelijk");
        tick(1'b0, 1'b1, 6, 7, 1'b0, 1'b1, "rust_same");
        idle(6, 7, 1'b1, "rust_hold");
        tick(1'b0, 1'b0, 7, 7, 1'b1, 1'b0, "rust_rise");

        // A SAME between DROP runs clears the calm counter.
        for (int j = 0; j < 5; j++) tick(1'b1, 1'b0, 7, 7, 1'b0, 1'b0, "drop_run1");
        tick(1'b0, 1'b1, 7, 7, 1'b0, 1'b0, "same_clears_calm");
        for (int j = 0; j < 5; j++) tick(1'b1, 1'b0, 7, 7, 1'b0, 1'b0, "drop_run2");
        tick(1'b1, 1'b0, 7, 7, 1'b0, 1'b1, "enter_rust_again");
        tick(1'b0, 1'b0, 6, 7, 1'b1, 1'b0, "rust_rise_down");

        // 6: mid-run reset with a RISE tick, then aan=0 for one cycle.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, "midrun_reset");
        same4(2, 2, 3, 2, 1'b1, "post_reset_step");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, "aan_off");
        idle(2, 2, 1'b0, "after_aan_off");
        tick(1'b0, 1'b0, 1, 2, 1'b1, 1'b0, "rise_after_aan_off");
        idle(1, 2, 1'b0, "final_idle");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wieg_strategie.md
Name: wieg_strategie

Overview:
- Downstream consumer of the stress evaluator's `gedaald`/`gelijk` verdicts.
- On every 12-unit evaluation tick, decides how the rocking setpoints change:
  - amplitude and frequency, 3 bits each.
  - Rising stress reverses the search direction; stagnant stress triggers a periodic exploratory step; falling stress holds the setting.
- Outputs feed the motor driver, which latches new setpoints on the `nieuw` pulse.

Parameters:
- AMP_INIT, 2, amplitude setpoint after reset or while disabled (0..7).
- FREQ_INIT, 2, frequency setpoint after reset or while disabled (0..7).
- STALE_MAX, 4, consecutive "gelijk" ticks before an exploratory step (1..15).
- CALM_MAX, 6, consecutive "gedaald" ticks before entering RUST (1..15).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- clk12  in  1  evaluation tick; one-cycle enable pulse synchronous to clk.
- aan  in  1  rocker enabled; 0 forces the idle/init condition.
- gedaald  in  1  stress dropped since the last evaluation; sampled only when clk12=1.
- gelijk  in  1  stress unchanged; sampled only when clk12=1.
- amplitude  out  3  rocking amplitude setpoint.
- frequentie  out  3  rocking frequency setpoint.
- nieuw  out  1  one-cycle pulse: a setpoint changed this cycle.
- klaar  out  1  baby calm; high while in RUST.

Behaviour:
- One clock, clk; reset is synchronous and active-high. reset has priority over aan and clk12 in the same cycle.
- Reset values:
  - amplitude=AMP_INIT, frequentie=FREQ_INIT, nieuw=0, klaar=0.
  - State=ZOEK, dim=AMP, dir=UP, stale=0, calm=0.
- aan=0: same register values as reset, applied every cycle. Any clk12 pulse is ignored.
- All outputs are registered. The decision for a tick sampled in cycle N is visible in cycle N+1; nieuw pulses in N+1 only.
- Tick classification, evaluated only when clk12=1 and aan=1; gedaald has priority:
  - DROP: gedaald=1, regardless of gelijk.
  - SAME: gedaald=0, gelijk=1.
  - RISE: gedaald=0, gelijk=0.
- STEP(d) on the active dimension dim:
  - If the target ≠ its bound in direction d (7 for UP, 0 for DOWN): add or subtract 1 and pulse nieuw.
  - Else toggle dim and apply the step to the other dimension in direction d if possible, pulsing nieuw.
  - If both dimensions sit at the bound: no setpoint change, dir is inverted, nieuw=0.
  - Setpoints never wrap.
- State ZOEK (search):
  - DROP: stale←0; calm←calm+1. If the new calm equals CALM_MAX: go to RUST, klaar←1, calm←0.
  - SAME: calm←0; stale←stale+1. If the new stale equals STALE_MAX: STEP(dir), stale←0.
  - RISE: calm←0, stale←0; dir←¬dir, then STEP(new dir).
- State RUST (calm): setpoints held, klaar=1.
  - DROP or SAME: remain in RUST; counters stay 0.
  - RISE: go to ZOEK, klaar←0; dir←¬dir, then STEP(new dir) in the same decision.
- No tick (clk12=0): all state is held and nieuw=0.
- clk12 high on consecutive cycles: each cycle is a separate tick. The block is not required to filter this.
- Counter widths are 4 bits. Counters never exceed their limit because they are cleared on reaching it.

Test Plan:
1. Reset with defaults, then aan=1 and 4 SAME ticks → after the 4th tick amplitude 2→3 (dim=AMP, dir=UP), nieuw high for exactly 1 cycle, frequentie=2.
2. From amplitude=3, frequentie=2, dir=UP: one RISE tick → amplitude=2, dir=DOWN, nieuw pulse; the next RISE tick → amplitude=3, dir=UP.
3. Bound handover: drive amplitude to 7 with dir=UP, then 4 SAME ticks → amplitude stays 7, frequentie 2→3, dim=FREQ.
4. Both at 7 with dir=UP, STALE_MAX SAME ticks → no change, nieuw=0, dir=DOWN; the next exploratory step decrements.
5. 6 consecutive DROP ticks → klaar=1 one cycle after the 6th tick. Then a DROP with gelijk=1 keeps klaar=1. A RISE clears klaar and steps the active dimension opposite to the prior dir.
6. Mid-run: reset asserted in the same cycle as clk12 with RISE → next cycle shows init setpoints, nieuw=0. Separately, aan=0 for 1 cycle also restores init values.
